fx3_tx_burst_fifo: RTL and testbench
====================================

Name: fx3_tx_burst_fifo

Overview:
Parametrised successor to the FX3 transmit FIFO. Buffers a DW-bit stream from the SoC side and releases it to the FX3 GPIF master side only in bursts, gated by a runtime watermark. Adds an explicit flush, a level output, a sticky overflow flag and an optional idle-timeout flush. Sits between the TX DMA/stream source and the FX3 GPIF write state machine.

Parameters:
DW, 16, data width in bits (8..64)
AW, 9, log2 of FIFO depth; DEPTH = 2**AW words
TO_W, 16, width of idle-timeout counter and its limit input

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_data_i  in  DW  write data
s_valid_i  in  1  write request
s_ready_o  out  1  FIFO not full
m_data_o  out  DW  read data, first-word-fall-through
m_valid_o  out  1  word available and burst gate open
m_ready_i  in  1  read accept
thresh_i  in  AW+1  burst watermark in words; 0 treated as 1; values above DEPTH treated as DEPTH
flush_i  in  1  one-cycle pulse: release partial burst
idle_lim_i  in  TO_W  idle cycles before auto-flush (0 = disabled)
level_o  out  AW+1  registered word count
gate_o  out  1  burst gate state (1 = BURST)
ovf_o  out  1  sticky overflow flag
ovf_clr_i  in  1  clears ovf_o

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr = rd_ptr = 0, level_o = 0, gate_o = 0, ovf_o = 0, flush_pend = 0, idle counter = 0. While in reset: s_ready_o = 1, m_valid_o = 0. Reset mid-burst discards all contents.
- Write: wr = s_valid_i & s_ready_o. s_ready_o = (level_o != DEPTH), combinational from registered level.
- Read: rd = m_valid_o & m_ready_i. m_data_o = mem[rd_ptr], asynchronous read. A written word is visible at m_data_o on the cycle after the write.
- Pointers are AW bits and wrap naturally. level_o = level + wr - rd, never exceeding DEPTH or dropping below 0.
- Simultaneous wr and rd: level unchanged. Write while full: word dropped, s_ready_o stays 0, ovf_o set the next cycle.
- ovf_o: set on s_valid_i & !s_ready_o; cleared on ovf_clr_i. Set has priority over clear.
- Gate FSM, two states:
  - IDLE: m_valid_o = 0. Go to BURST when level_o >= thresh_eff, or when (flush_pend | timeout) & level_o != 0.
  - BURST: m_valid_o = (level_o != 0). Go to IDLE on rd & (level_o == 1) & !wr, i.e. the FIFO drains to empty. Writes during BURST extend the burst.
- flush_i: sets flush_pend. flush_pend clears on entry to BURST. flush_i while level 0 in IDLE is held pending until data arrives. flush_i in BURST is ignored.
- thresh_i is compared combinationally every cycle. Lowering it below the current level opens the gate on the next edge.

Optional Feature:
FX3_TX_TIMEOUT_EN
- Defined: TO_W-bit idle counter.
  - Counts in IDLE while level_o != 0, wr = 0 and idle_lim_i != 0.
  - Resets to 0 on any wr, in BURST, or when level_o = 0.
  - timeout asserts when counter == idle_lim_i - 1 with a count enable that cycle, so the gate opens exactly idle_lim_i idle cycles after the last write.
  - Counter saturates; it does not wrap.
- Not defined: timeout is constant 0, no counter is instantiated, idle_lim_i is unused.

Decomposition:
- Package fx3_tx_pkg: gate state enum (GATE_IDLE, GATE_BURST) and a function clamping thresh_i to 1..DEPTH.
- Sub-module fx3_tx_dpram: DW x DEPTH storage, synchronous write, asynchronous read.
- The top module holds pointers, level, gate FSM, flush and timeout logic.

Test Plan:
1. AW=4, thresh_i=8: write 7 words -> m_valid_o stays 0, level_o=7. Write 8th -> gate_o=1 next cycle. Read 8 -> words 0..7 in order, gate_o=0 after the last read.
2. thresh_i=8, write 3 words, pulse flush_i -> gate opens next cycle, 3 words drain, gate closes. flush_i with empty FIFO, then 1 write -> gate opens one cycle after the write.
3. DEPTH=16, write 17 words with m_ready_i=0 -> s_ready_o=0 at level 16, 17th word dropped, ovf_o=1 until ovf_clr_i.
4. In BURST, write and read every cycle for 100 cycles -> level constant, gate stays 1, data order preserved across pointer wrap.
5. Assert rst_n low mid-burst with level 10 -> outputs immediately at reset values. After release, first new word written reads out correctly.
6. With FX3_TX_TIMEOUT_EN, idle_lim_i=5, thresh_i=8: write 2 words then idle -> gate opens exactly 5 cycles after the last write. With the macro undefined -> the gate never opens.

Source files
------------

// File: rtl/fx3_tx_pkg.sv
// rtl/fx3_tx_pkg.sv - shared gate-state encodings and watermark clamp for the FX3 TX burst FIFO
package fx3_tx_pkg;

    // Gate FSM encoding. These are plain constants rather than an enum so
    // legacy code can keep comparing the state as raw bits.
    typedef logic [0:0] gate_state_t;
    localparam gate_state_t GATE_IDLE  = 1'b0;
    localparam gate_state_t GATE_BURST = 1'b1;

    // Clamp a raw watermark into 1..depth. A zero watermark would otherwise
    // open the gate on an empty FIFO, and a watermark above depth could never
    // be reached.
    function automatic int unsigned clamp_thresh(input int unsigned t, input int unsigned depth);
        if (t == 0)
            return 1;
        else if (t > depth)
            return depth;
        else
            return t;
    endfunction

endpackage

// File: rtl/fx3_tx_burst_fifo_if.sv
// rtl/fx3_tx_burst_fifo_if.sv - write/read stream handshake bundle for fx3_tx_burst_fifo
//   s_data_i/s_valid_i/s_ready_o : SoC-side write stream
//   m_data_o/m_valid_o/m_ready_i : GPIF-side read stream (first-word-fall-through)
//   slave modport  : FIFO view
//   master modport : source/sink environment view
interface fx3_tx_burst_fifo_if #(
    parameter int DW = 16
);
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;

    modport slave (
        input  s_data_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_valid_o
    );

    modport master (
        output s_data_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_valid_o
    );
endinterface

// File: rtl/fx3_tx_dpram.sv
// rtl/fx3_tx_dpram.sv - DW x 2**AW storage, synchronous write, asynchronous read
//   clk   : write clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : read data (combinational)
module fx3_tx_dpram #(
    parameter int DW = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fx3_tx_burst_fifo.sv
// rtl/fx3_tx_burst_fifo.sv - burst-gated transmit FIFO between the TX stream source and the FX3 GPIF writer
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : write stream in, FWFT read stream out
//   thresh_i     : burst watermark (0 -> 1, >DEPTH -> DEPTH)
//   flush_i      : pulse, releases a partial burst
//   idle_lim_i   : idle cycles before auto-flush, 0 disables
//   level_o      : registered word count
//   gate_o       : 1 while the burst gate is open
//   ovf_o        : sticky overflow, cleared by ovf_clr_i
//   Build option FX3_TX_TIMEOUT_EN adds the idle-timeout auto-flush.
module fx3_tx_burst_fifo
    import fx3_tx_pkg::*;
#(
    parameter int DW   = 16,
    parameter int AW   = 9,
    parameter int TO_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    fx3_tx_burst_fifo_if.slave  bus,
    input  logic [AW:0]         thresh_i,
    input  logic                flush_i,
    input  logic [TO_W-1:0]     idle_lim_i,
    output logic [AW:0]         level_o,
    output logic                gate_o,
    output logic                ovf_o,
    input  logic                ovf_clr_i
);
    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    gate_state_t   state;
    logic          ovf_q;
    logic          flush_pend;
    logic          timeout;
    logic          wr, rd;
    logic [AW:0]   thresh_eff;
    logic          open_gate;
    logic [DW-1:0] rdata;

    assign thresh_eff = (AW+1)'(clamp_thresh(32'(thresh_i), DEPTH));

    assign bus.s_ready_o = (level != DEPTH_W);
    assign bus.m_valid_o = (state == GATE_BURST) && (level != '0);
    assign bus.m_data_o  = rdata;
    assign wr = bus.s_valid_i & bus.s_ready_o;
    assign rd = bus.m_valid_o & bus.m_ready_i;

    assign level_o = level;
    assign gate_o  = (state == GATE_BURST);
    assign ovf_o   = ovf_q;

    fx3_tx_dpram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr),
        .waddr (wr_ptr),
        .wdata (bus.s_data_i),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // IDLE -> BURST: watermark reached, or a pending flush/timeout with data to send.
    assign open_gate = (state == GATE_IDLE) &&
                       ((level >= thresh_eff) || ((flush_pend | timeout) && (level != '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            state      <= GATE_IDLE;
            ovf_q      <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;

            case ({wr, rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (bus.s_valid_i && !bus.s_ready_o)
                ovf_q <= 1'b1;
            else if (ovf_clr_i)
                ovf_q <= 1'b0;

            // A flush seen in IDLE is remembered even on an empty FIFO, so the
            // next word goes out without waiting for the watermark.
            if (open_gate)
                flush_pend <= 1'b0;
            else if (flush_i && state == GATE_IDLE)
                flush_pend <= 1'b1;

            if (open_gate)
                state <= GATE_BURST;
            else if (state == GATE_BURST && rd && level == (AW+1)'(1) && !wr)
                state <= GATE_IDLE;
        end
    end

`ifdef FX3_TX_TIMEOUT_EN
    logic [TO_W-1:0] idle_cnt;
    logic            cnt_en;

    assign cnt_en  = (state == GATE_IDLE) && (level != '0) && !wr && (idle_lim_i != '0);
    // Fires on the last counted cycle so the gate edge lands exactly
    // idle_lim_i cycles after the last write.
    assign timeout = cnt_en && (idle_cnt == idle_lim_i - TO_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (wr || state == GATE_BURST || level == '0)
            idle_cnt <= '0;
        else if (cnt_en && idle_cnt != '1)
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    logic unused_idle_lim;
    assign unused_idle_lim = ^idle_lim_i;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fx3_tx_burst_fifo.sv
// tb/tb_fx3_tx_burst_fifo.sv - directed self-checking bench for fx3_tx_burst_fifo
module tb_fx3_tx_burst_fifo;
    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int TO_W = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW:0]     thresh_i;
    logic            flush_i;
    logic [TO_W-1:0] idle_lim_i;
    logic [AW:0]     level_o;
    logic            gate_o;
    logic            ovf_o;
    logic            ovf_clr_i;

    int n_tests = 0;
    int n_fail  = 0;
    int wseq, rseq;

    fx3_tx_burst_fifo_if #(.DW(DW)) bus ();

    fx3_tx_burst_fifo #(.DW(DW), .AW(AW), .TO_W(TO_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .thresh_i   (thresh_i),
        .flush_i    (flush_i),
        .idle_lim_i (idle_lim_i),
        .level_o    (level_o),
        .gate_o     (gate_o),
        .ovf_o      (ovf_o),
        .ovf_clr_i  (ovf_clr_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.s_data_i  = '0;
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b0;
        thresh_i      = 5'd8;
        flush_i       = 1'b0;
        idle_lim_i    = '0;
        ovf_clr_i     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_level",  32'(level_o), 32'd0);
        check("rst_gate",   32'(gate_o), 32'd0);
        check("rst_sready", 32'(bus.s_ready_o), 32'd1);
        check("rst_mvalid", 32'(bus.m_valid_o), 32'd0);
        check("rst_ovf",    32'(ovf_o), 32'd0);
        rst_n = 1'b1;

        // 1: watermark burst
        for (int i = 0; i < 7; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 16'(16'h0100 + i);
            tick();
        end
        bus.s_valid_i = 1'b0;
        check("t1_level7",  32'(level_o), 32'd7);
        check("t1_mvalid7", 32'(bus.m_valid_o), 32'd0);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 16'h0107;
        tick();
        bus.s_valid_i = 1'b0;
        check("t1_level8", 32'(level_o), 32'd8);
        check("t1_gate_pre", 32'(gate_o), 32'd0);
        tick();
        check("t1_gate_open", 32'(gate_o), 32'd1);
        check("t1_mvalid", 32'(bus.m_valid_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("t1_rdata", 32'(bus.m_data_o), 32'h0100 + 32'(i));
            bus.m_ready_i = 1'b1;
            tick();
        end
        bus.m_ready_i = 1'b0;
        check("t1_gate_close", 32'(gate_o), 32'd0);
        check("t1_level0", 32'(level_o), 32'd0);

        // 2: flush of a partial burst, then flush on empty held pending
        for (int i = 0; i < 3; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 16'(16'h0200 + i);
            tick();
        end
        bus.s_valid_i = 1'b0;
        check("t2_gate_idle", 32'(gate_o), 32'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        check("t2_gate_flush", 32'(gate_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("t2_rdata", 32'(bus.m_data_o), 32'h0200 + 32'(i));
            bus.m_ready_i = 1'b1;
            tick();
        end
        bus.m_ready_i = 1'b0;
        check("t2_gate_close", 32'(gate_o), 32'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        tick();
        check("t2_empty_flush_gate", 32'(gate_o), 32'd0);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 16'h02AA;
        tick();
        bus.s_valid_i = 1'b0;
        check("t2_level1", 32'(level_o), 32'd1);
        tick();
        check("t2_pend_gate", 32'(gate_o), 32'd1);
        check("t2_pend_data", 32'(bus.m_data_o), 32'h02AA);
        bus.m_ready_i = 1'b1;
        tick();
        bus.m_ready_i = 1'b0;
        check("t2_pend_close", 32'(gate_o), 32'd0);

        // 3: overflow
        for (int i = 0; i < 17; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 16'(16'h0300 + i);
            if (i == 16) begin
                check("t3_sready_full", 32'(bus.s_ready_o), 32'd0);
                check("t3_ovf_pre", 32'(ovf_o), 32'd0);
            end
            tick();
        end
        bus.s_valid_i = 1'b0;
        check("t3_ovf_set", 32'(ovf_o), 32'd1);
        check("t3_level16", 32'(level_o), 32'd16);
        tick();
        check("t3_ovf_sticky", 32'(ovf_o), 32'd1);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("t3_ovf_clr", 32'(ovf_o), 32'd0);
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_rdata", 32'(bus.m_data_o), 32'h0300 + 32'(i));
            tick();
        end
        bus.m_ready_i = 1'b0;
        check("t3_level0", 32'(level_o), 32'd0);
        check("t3_gate_close", 32'(gate_o), 32'd0);

        // 4: streaming through a held-open burst across pointer wrap
        wseq = 0;
        rseq = 0;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 16'(16'h0400 + wseq);
            wseq++;
            tick();
        end
        bus.s_valid_i = 1'b0;
        tick();
        check("t4_gate_open", 32'(gate_o), 32'd1);
        bus.s_valid_i = 1'b1;
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("t4_rdata", 32'(bus.m_data_o), 32'h0400 + 32'(rseq));
            bus.s_data_i = 16'(16'h0400 + wseq);
            tick();
            wseq++;
            rseq++;
            check("t4_level", 32'(level_o), 32'd8);
            check("t4_gate", 32'(gate_o), 32'd1);
        end
        bus.s_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t4_drain", 32'(bus.m_data_o), 32'h0400 + 32'(rseq));
            rseq++;
            tick();
        end
        bus.m_ready_i = 1'b0;
        check("t4_gate_close", 32'(gate_o), 32'd0);

        // 5: asynchronous reset mid-burst
        for (int i = 0; i < 10; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 16'(16'h0500 + i);
            tick();
        end
        bus.s_valid_i = 1'b0;
        check("t5_level10", 32'(level_o), 32'd10);
        check("t5_gate", 32'(gate_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_level",  32'(level_o), 32'd0);
        check("t5_rst_gate",   32'(gate_o), 32'd0);
        check("t5_rst_mvalid", 32'(bus.m_valid_o), 32'd0);
        check("t5_rst_sready", 32'(bus.s_ready_o), 32'd1);
        tick();
        rst_n    = 1'b1;
        thresh_i = 5'd1;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 16'h5A5A;
        tick();
        bus.s_valid_i = 1'b0;
        check("t5_new_level", 32'(level_o), 32'd1);
        tick();
        check("t5_new_gate", 32'(gate_o), 32'd1);
        check("t5_new_data", 32'(bus.m_data_o), 32'h5A5A);
        bus.m_ready_i = 1'b1;
        tick();
        bus.m_ready_i = 1'b0;
        check("t5_new_close", 32'(gate_o), 32'd0);

        // 6: idle timeout
        thresh_i   = 5'd8;
        idle_lim_i = 16'd5;
        for (int i = 0; i < 2; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 16'(16'h0600 + i);
            tick();
        end
        bus.s_valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t6_gate_wait", 32'(gate_o), 32'd0);
        end
        tick();
`ifdef FX3_TX_TIMEOUT_EN
        check("t6_gate_timeout", 32'(gate_o), 32'd1);
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("t6_rdata", 32'(bus.m_data_o), 32'h0600 + 32'(i));
            tick();
        end
        bus.m_ready_i = 1'b0;
        check("t6_gate_close", 32'(gate_o), 32'd0);
`else
        check("t6_gate_no_timeout", 32'(gate_o), 32'd0);
        repeat (20) tick();
        check("t6_gate_never", 32'(gate_o), 32'd0);
        check("t6_level2", 32'(level_o), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
